// File: rtl/rf_sched_pkg.sv
// rf_sched_pkg: shared state encoding and default widths for the register-file port scheduler.
package rf_sched_pkg;
  localparam int WS_DEF = 32;
  localparam int RC_DEF = 32;
  localparam int STARVE_DEF = 8;
  typedef enum logic [2:0] {IDLE, RD1, RD2, RESP, DBG} rf_sched_state_e;
endpackage

// File: rtl/rf_port_sched_rf.sv
// rf: single-port register file, write on posedge, combinational read; contents are never reset.
module rf #(
  parameter int WORD_SIZE = 32,
  parameter int REG_COUNT = 32,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_SIZE-1:0] wdata,
  output logic [WORD_SIZE-1:0] rdata
);
  logic [WORD_SIZE-1:0] r_mem [REG_COUNT];
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end
  assign rdata = r_mem[addr];
endmodule

// File: rtl/rf_port_sched.sv
// rf_port_sched: arbitrates the single rf port between writeback, two-operand fetch and debug reads,
// with a starvation counter that eventually lifts debug to top priority.
module rf_port_sched
  import rf_sched_pkg::*;
#(
  parameter int WORD_SIZE = WS_DEF,
  parameter int REG_COUNT = RC_DEF,
  parameter int STARVE_LIMIT = STARVE_DEF,
  localparam int AW = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid,
  output logic                 wb_ready,
  input  logic [AW-1:0]        wb_rd,
  input  logic [WORD_SIZE-1:0] wb_data,
  input  logic                 fe_valid,
  output logic                 fe_ready,
  input  logic [AW-1:0]        fe_rs1,
  input  logic [AW-1:0]        fe_rs2,
  output logic                 op_valid,
  input  logic                 op_ready,
  output logic [WORD_SIZE-1:0] op_rs1_data,
  output logic [WORD_SIZE-1:0] op_rs2_data,
  input  logic                 dbg_valid,
  output logic                 dbg_ready,
  input  logic [AW-1:0]        dbg_addr,
  output logic                 dbg_rvalid,
  output logic [WORD_SIZE-1:0] dbg_rdata,
  output logic                 busy
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  rf_sched_state_e r_state, w_next;
  logic [SW-1:0] r_starve;
  logic [AW-1:0] r_rs1, r_rs2, r_dbg_addr, w_rf_addr;
  logic [WORD_SIZE-1:0] r_op1, r_op2, r_dbg_rdata, w_rf_wdata, w_rf_rdata;
  logic r_dbg_rvalid, w_rf_we, w_idle, w_starved, w_dbg_pri, w_wb_gnt, w_fe_gnt, w_dbg_gnt;
  assign w_idle = r_state == IDLE;
  assign w_starved = r_starve == SW'(STARVE_LIMIT);
  assign w_dbg_pri = w_starved && dbg_valid;
  assign w_wb_gnt = w_idle && wb_valid && !w_dbg_pri;
  assign w_fe_gnt = w_idle && fe_valid && !wb_valid && !w_dbg_pri;
  assign w_dbg_gnt = w_idle && dbg_valid && (w_starved || !(wb_valid || fe_valid));
  assign wb_ready = w_wb_gnt;
  assign fe_ready = w_fe_gnt;
  assign dbg_ready = w_dbg_gnt;
  assign op_valid = r_state == RESP;
  assign busy = !w_idle;
  assign op_rs1_data = r_op1;
  assign op_rs2_data = r_op2;
  assign dbg_rdata = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_dbg_gnt ? DBG : !w_fe_gnt ? IDLE : fe_rs1 != '0 ? RD1 : fe_rs2 != '0 ? RD2 : RESP;
      RD1: w_next = r_rs2 != '0 ? RD2 : RESP;
      RD2: w_next = RESP;
      RESP: w_next = op_ready ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  // x0 writes are acknowledged but suppressed at the port
  always_comb begin
    w_rf_we = w_wb_gnt && wb_rd != '0;
    w_rf_wdata = w_wb_gnt ? wb_data : '0;
    w_rf_addr = w_wb_gnt ? wb_rd : r_state == RD1 ? r_rs1 : r_state == RD2 ? r_rs2 : r_state == DBG ? r_dbg_addr : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rs1 <= '0;
      r_rs2 <= '0;
      r_op1 <= '0;
      r_op2 <= '0;
      r_dbg_addr <= '0;
      r_dbg_rdata <= '0;
      r_dbg_rvalid <= 1'b0;
      r_starve <= '0;
    end else begin
      if (w_fe_gnt) begin
        r_rs1 <= fe_rs1;
        r_rs2 <= fe_rs2;
        r_op1 <= '0;
        r_op2 <= '0;
      end
      if (r_state == RD1) r_op1 <= w_rf_rdata;
      if (r_state == RD2) r_op2 <= w_rf_rdata;
      if (w_dbg_gnt) r_dbg_addr <= dbg_addr;
      if (r_state == DBG) r_dbg_rdata <= r_dbg_addr == '0 ? '0 : w_rf_rdata;
      r_dbg_rvalid <= r_state == DBG;
      r_starve <= (!dbg_valid || w_dbg_gnt) ? '0 : (w_idle && !w_starved) ? r_starve + 1'b1 : r_starve;
    end
  end
  rf #(.WORD_SIZE(WORD_SIZE), .REG_COUNT(REG_COUNT)) u_rf (
    .clk(clk),
    .we(w_rf_we),
    .addr(w_rf_addr),
    .wdata(w_rf_wdata),
    .rdata(w_rf_rdata)
  );
endmodule

// File: tb/tb_rf_port_sched.sv
// tb_rf_port_sched: directed scenarios checked every cycle against a transaction-level scheduler model.
module tb_rf_port_sched;
  logic clk = 1'b0, rst = 1'b1;
  logic wb_valid = 1'b0, fe_valid = 1'b0, dbg_valid = 1'b0, op_ready = 1'b1;
  logic [4:0] wb_rd = '0, fe_rs1 = '0, fe_rs2 = '0, dbg_addr = '0;
  logic [31:0] wb_data = '0;
  logic wb_ready, fe_ready, dbg_ready, op_valid, dbg_rvalid, busy;
  logic [31:0] op_rs1_data, op_rs2_data, dbg_rdata;
  rf_port_sched dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .fe_valid(fe_valid), .fe_ready(fe_ready), .fe_rs1(fe_rs1), .fe_rs2(fe_rs2),
    .op_valid(op_valid), .op_ready(op_ready), .op_rs1_data(op_rs1_data), .op_rs2_data(op_rs2_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Model: register contents plus at most one outstanding fetch and one outstanding debug read.
  logic [31:0] mem [32];
  logic fe_pend = 1'b0, dbg_pend = 1'b0;
  int fe_acc, fe_lat, dbg_acc, starve = 0;
  logic [31:0] exp_op1, exp_op2, dbg_exp, exp_drd = '0;
  logic idle, starved, e_wb, e_fe, e_dbg, e_opv, e_rv;
  initial for (int i = 0; i < 32; i++) mem[i] = '0;
  always @(negedge clk) begin
    if (rst) begin
      fe_pend = 1'b0;
      dbg_pend = 1'b0;
      starve = 0;
      exp_drd = '0;
    end else begin
      idle = !(fe_pend && cyc > fe_acc) && !(dbg_pend && cyc == dbg_acc + 1);
      starved = starve == 8;
      e_dbg = idle && dbg_valid && (starved || (!wb_valid && !fe_valid));
      e_wb = idle && wb_valid && !(starved && dbg_valid);
      e_fe = idle && fe_valid && !wb_valid && !(starved && dbg_valid);
      e_opv = fe_pend && cyc >= fe_acc + fe_lat;
      e_rv = dbg_pend && cyc == dbg_acc + 2;
      chk("wb_ready", wb_ready, e_wb);
      chk("fe_ready", fe_ready, e_fe);
      chk("dbg_ready", dbg_ready, e_dbg);
      chk("rf_we", dut.w_rf_we, e_wb && wb_rd != 0);
      chk("busy", busy, !idle);
      chk("op_valid", op_valid, e_opv);
      if (e_opv && op_valid) begin
        chk("op_rs1_data", op_rs1_data, exp_op1);
        chk("op_rs2_data", op_rs2_data, exp_op2);
      end
      chk("dbg_rvalid", dbg_rvalid, e_rv);
      if (e_rv) begin
        exp_drd = dbg_exp;
        dbg_pend = 1'b0;
      end
      chk("dbg_rdata", dbg_rdata, exp_drd);
      if (e_opv && op_ready) fe_pend = 1'b0;
      if (e_wb && wb_rd != 0) mem[wb_rd] = wb_data;
      if (e_fe) begin
        fe_pend = 1'b1;
        fe_acc = cyc;
        fe_lat = 1 + int'(fe_rs1 != 0) + int'(fe_rs2 != 0);
        exp_op1 = fe_rs1 == 0 ? 32'h0 : mem[fe_rs1];
        exp_op2 = fe_rs2 == 0 ? 32'h0 : mem[fe_rs2];
      end
      if (e_dbg) begin
        dbg_pend = 1'b1;
        dbg_acc = cyc;
        dbg_exp = dbg_addr == 0 ? 32'h0 : mem[dbg_addr];
      end
      starve = (!dbg_valid || e_dbg) ? 0 : (idle && starve < 8) ? starve + 1 : starve;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // which: 0 wb_ready, 1 fe_ready, 2 dbg_ready, 3 op_valid, 4 dbg_rvalid
  task automatic wait_sig(input int which, input string nm, output int c);
    logic s;
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      s = which == 0 ? wb_ready : which == 1 ? fe_ready : which == 2 ? dbg_ready : which == 3 ? op_valid : dbg_rvalid;
      if (s) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout, event not seen within 40 cycles", nm);
    end
  endtask
  task automatic do_wb(input logic [4:0] rd, input logic [31:0] d);
    int c;
    wb_rd = rd;
    wb_data = d;
    wb_valid = 1'b1;
    wait_sig(0, "wb_accept", c);
    step();
    wb_valid = 1'b0;
  endtask
  task automatic do_fe(input logic [4:0] r1, input logic [4:0] r2, output int a);
    fe_rs1 = r1;
    fe_rs2 = r2;
    fe_valid = 1'b1;
    wait_sig(1, "fe_accept", a);
    step();
    fe_valid = 1'b0;
  endtask
  task automatic do_dbg(input logic [4:0] ad, output logic [31:0] d);
    int g, r;
    dbg_addr = ad;
    dbg_valid = 1'b1;
    wait_sig(2, "dbg_accept", g);
    step();
    dbg_valid = 1'b0;
    wait_sig(4, "dbg_rvalid", r);
    chk("dbg_rvalid_lat", r - g, 2);
    d = dbg_rdata;
    step();
  endtask
  initial begin
    int a, c, s, g;
    logic [31:0] d;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_op1", op_rs1_data, 0);
    chk("rst_dbg_rdata", dbg_rdata, 0);
    step();
    wb_rd = 5; wb_data = 32'hDEADBEEF; wb_valid = 1'b1; s = cyc;
    wait_sig(0, "s1_wb", c);
    chk("s1_wb_same_cycle", c - s, 0);
    step();
    wb_valid = 1'b0;
    op_ready = 1'b0;
    do_fe(5, 5, a);
    wait_sig(3, "s1_op", c);
    chk("s1_latency", c - a, 3);
    chk("s1_rs1", op_rs1_data, 32'hDEADBEEF);
    chk("s1_rs2", op_rs2_data, 32'hDEADBEEF);
    repeat (2) step();
    op_ready = 1'b1;
    step();
    do_wb(0, 32'h1234);
    do_fe(0, 0, a);
    wait_sig(3, "s2_op", c);
    chk("s2_latency", c - a, 1);
    chk("s2_rs1", op_rs1_data, 0);
    chk("s2_rs2", op_rs2_data, 0);
    step();
    wb_rd = 3; wb_data = 7; wb_valid = 1'b1;
    fe_rs1 = 3; fe_rs2 = 0; fe_valid = 1'b1; s = cyc;
    wait_sig(0, "s3_wb", c);
    chk("s3_wb_first", c - s, 0);
    step();
    wb_valid = 1'b0;
    wait_sig(1, "s3_fe", a);
    chk("s3_fe_next", a - c, 1);
    step();
    fe_valid = 1'b0;
    wait_sig(3, "s3_op", c);
    chk("s3_latency", c - a, 2);
    chk("s3_rs1", op_rs1_data, 7);
    step();
    do_wb(4, 1);
    do_fe(4, 0, a);
    wb_rd = 4; wb_data = 2; wb_valid = 1'b1;
    wait_sig(3, "s4_op", c);
    chk("s4_rs1", op_rs1_data, 1);
    wait_sig(0, "s4_wb", s);
    chk("s4_wb_after_resp", s - c, 1);
    step();
    wb_valid = 1'b0;
    do_dbg(4, d);
    chk("s4_x4", d, 2);
    dbg_addr = 5; dbg_valid = 1'b1;
    wb_rd = 7; wb_data = 32'h77; wb_valid = 1'b1; s = cyc;
    wait_sig(2, "s5_dbg", g);
    chk("s5_starve_cycles", g - s, 8);
    step();
    dbg_valid = 1'b0;
    wb_valid = 1'b0;
    wait_sig(4, "s5_rvalid", c);
    chk("s5_rdata", dbg_rdata, 32'hDEADBEEF);
    step();
    do_dbg(0, d);
    chk("dbg_x0", d, 0);
    do_dbg(7, d);
    chk("dbg_x7", d, 32'h77);
    do_wb(6, 32'h66);
    do_fe(6, 6, a);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("s6_op_valid", op_valid, 0);
    chk("s6_busy", busy, 0);
    repeat (6) step();
    do_fe(6, 0, a);
    wait_sig(3, "s6_op", c);
    chk("s6_latency", c - a, 2);
    chk("s6_rs1", op_rs1_data, 32'h66);
    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
